// File: rtl/frame_windower.sv
// frame_windower: buffers PCM samples into overlapping frames and emits them
// oldest first, each multiplied by its ROM window coefficient and rounded.
module frame_windower #(
  parameter int FRAME_LEN = 16,
  parameter int ADDR_W    = 4,
  parameter int HOP       = 8,
  parameter int DATA_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic        [ADDR_W-1:0] coef_addr,
  input  logic               [7:0] coef_in,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);
  typedef enum logic {FILL, EMIT} state_t;
  localparam logic [ADDR_W-1:0] HOP_A  = ADDR_W'(HOP % FRAME_LEN);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   FULL_C = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0]   HOP_C  = (ADDR_W+1)'(HOP);
  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_buf [FRAME_LEN];
  logic        [ADDR_W-1:0]  r_wptr, r_base, r_idx;
  logic        [ADDR_W:0]    r_fill;
  logic                      r_first;
  logic                      w_acc, w_load, w_fill_done;
  logic        [ADDR_W:0]    w_fill_nx;
  logic        [ADDR_W-1:0]  w_raddr;
  logic signed [DATA_W-1:0]  w_samp, w_out;
  logic signed [DATA_W+8:0]  w_prod, w_sum;
  assign in_ready    = rst_n && r_state == FILL;
  assign coef_addr   = rst_n ? r_idx : '0;
  assign w_acc       = in_valid && in_ready;
  assign w_load      = r_state == EMIT && (!out_valid || out_ready);
  assign w_fill_nx   = r_fill + (ADDR_W+1)'(1);
  // the very first frame needs a full buffer; later ones only HOP fresh samples
  assign w_fill_done = w_fill_nx == (r_first ? FULL_C : HOP_C);
  assign w_raddr     = r_base + r_idx;
  assign w_samp      = r_buf[w_raddr];
  assign w_prod      = $signed(w_samp) * $signed({1'b0, coef_in});
  assign w_sum       = w_prod + (DATA_W+9)'(128);
  assign w_out       = DATA_W'(w_sum >>> 8);
  always_ff @(posedge clk)
    if (w_acc) r_buf[r_wptr] <= in_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= FILL;
      r_wptr    <= '0;
      r_base    <= '0;
      r_fill    <= '0;
      r_idx     <= '0;
      r_first   <= 1'b1;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (w_load) begin
        out_data  <= w_out;
        out_valid <= 1'b1;
        out_last  <= r_idx == LAST_A;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (r_state == FILL) begin
        if (w_acc) begin
          r_wptr <= r_wptr + ADDR_W'(1);
          r_fill <= w_fill_done ? '0 : w_fill_nx;
          if (w_fill_done) begin
            r_idx   <= '0;
            r_first <= 1'b0;
            r_state <= EMIT;
          end
        end
      end else if (w_load) begin
        r_idx <= r_idx + ADDR_W'(1);
        if (r_idx == LAST_A) begin
          r_base  <= r_base + HOP_A;
          r_state <= FILL;
        end
      end
    end
  end
endmodule

// File: tb/tb_frame_windower.sv
// tb_frame_windower: random stimulus against a stream-level model where frame k
// is stream[k*HOP +: FRAME_LEN], each sample windowed by rom[j] and rounded.
module tb_frame_windower;
  localparam int FL = 16;
  localparam int AW = 4;
  localparam int HOP = 8;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW-1:0] in_data, out_data;
  logic [AW-1:0] coef_addr;
  logic [7:0] coef_in;
  logic [7:0] rom [FL];
  int total = 0, bad = 0;
  int sq[$];
  int hs, cyc, t0, t15;
  int dmode, dval, vprob, rprob;
  bit pstall;
  int pd, pl;
  frame_windower #(.FRAME_LEN(FL), .ADDR_W(AW), .HOP(HOP), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .coef_addr(coef_addr), .coef_in(coef_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );
  always #5 clk = ~clk;
  assign coef_in = rom[coef_addr];
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int win(input int s, input int c);
    return (s * c + 128) >>> 8;
  endfunction
  task automatic drive();
    in_valid  = $urandom_range(99) < vprob;
    out_ready = $urandom_range(99) < rprob;
    in_data   = dmode == 0 ? DW'(dval) : dmode == 1 ? DW'(sq.size()) : DW'($urandom);
  endtask
  task automatic mon();
    int loads, f, k, j, idx;
    loads = hs + int'(out_valid);
    f = loads / FL;
    chk("coef_addr", int'(coef_addr), loads % FL);
    chk("in_ready", int'(in_ready), int'(sq.size() < f * HOP + FL));
    if (pstall) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'($signed(out_data)), pd);
      chk("hold_last", int'(out_last), pl);
    end
    pstall = out_valid && !out_ready;
    pd = int'($signed(out_data));
    pl = int'(out_last);
    if (in_valid && in_ready) sq.push_back(int'($signed(in_data)));
    if (out_valid && out_ready) begin
      k = hs / FL;
      j = hs % FL;
      idx = k * HOP + j;
      if (hs == 0) t0 = cyc;
      if (hs == FL - 1) t15 = cyc;
      if (idx >= sq.size()) chk("early_output", idx, sq.size());
      else chk("out_data", int'($signed(out_data)), win(sq[idx], int'(rom[j])));
      chk("out_last", int'(out_last), int'(j == FL - 1));
      hs++;
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      mon();
      cyc++;
    end
  endtask
  task automatic clear_model();
    sq.delete();
    hs = 0;
    pstall = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_coef_addr", int'(coef_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_data", int'($signed(out_data)), 0);
    chk("rst_fill_ready", int'(in_ready), 1);
  endtask
  task automatic reset_at_idx5();
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      mon();
      cyc++;
      hit = !in_ready && coef_addr == AW'(5);
    end
    if (!hit) begin
      chk("reach_idx5", 0, 1);
      return;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_coef_addr", int'(coef_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    clear_model();
    @(negedge clk);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_fill", int'(in_ready), 1);
    chk("mid_rst_coef0", int'(coef_addr), 0);
  endtask
  task automatic rom_const(input int c);
    for (int i = 0; i < FL; i++) rom[i] = 8'(c);
  endtask
  task automatic rom_rand();
    for (int i = 0; i < FL; i++) rom[i] = 8'($urandom);
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cyc = 0; t0 = -1000; t15 = 0;
    clear_model();
    rom_const(8'hFF);
    dmode = 0; dval = 1000; vprob = 100; rprob = 100;
    do_reset();
    run(60);
    chk("throughput", t15 - t0, FL - 1);
    chk("ref_996", win(1000, 255), 996);
    dval = -1000;
    do_reset();
    run(40);
    rom_const(8'h0F);
    dval = 1000;
    do_reset();
    run(40);
    rom_const(8'hFF);
    dval = -32768;
    do_reset();
    run(40);
    chk("ref_min", win(-32768, 255), -32640);
    dmode = 1;
    do_reset();
    run(90);
    chk("ramp_frames", int'(hs >= 3 * FL), 1);
    rom_rand();
    dmode = 2; vprob = 60; rprob = 50;
    do_reset();
    run(1500);
    vprob = 70; rprob = 80;
    do_reset();
    reset_at_idx5();
    run(300);
    vprob = 100; rprob = 30;
    run(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
